// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the data-memory arbiter.
//   CPU_ADDR_W / CPU_DATA_W : default data memory address and word widths
//   arb_state_e             : arbiter ownership states
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundle of the two requester ports and the data memory port.
//   reqN/weN/addrN/wdataN : access request from port N (0 = CPU, 1 = loader)
//   gntN/rvalidN/rdataN   : grant, read-valid and read data back to port N
//   mem_*                 : single-port data memory strobe, address and data
// Modports:
//   slave  : arbiter view (requests and mem_rdata in, grants and mem_* out)
//   master : requester/memory side (the opposite direction)
interface dm_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-request round-robin picker.
//   req0, req1 : pending requests
//   last       : port served most recently
//   winner     : chosen port; only meaningful when req0 | req1
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ~last;  // tie goes to the port not served last
    else if (req1)    winner = 1'b1;
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing one single-port data memory between
// the CPU (port 0) and the program/debug loader (port 1).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dm_arbiter_if.slave carrying both request ports and the
//                memory port
// The owner keeps the memory while it requests, up to BURST_MAX consecutive
// accepts while the other port waits; read data comes back one cycle after
// the accept, tagged with rvalid for the issuing port.
module dm_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = CPU_ADDR_W,
  parameter int DATA_W    = CPU_DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);

  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  arb_state_e        state, state_n;
  logic              last, last_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              winner;
  logic              own;       // current owner when in an OWN state
  logic              own_req;
  logic              oth_req;
  logic              sel;       // port steering the memory bus
  logic              gnt0, gnt1;
  logic              mem_en, mem_we;
  logic              rvalid0, rvalid1;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  rr_pick2 u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last),
    .winner (winner)
  );

  // NOTE: non-blocking assignments for every register so all flops update
  // from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      last    <= 1'b1;
      cnt     <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      cnt     <= cnt_n;
      rvalid0 <= gnt0 & bus.req0 & ~bus.we0;
      rvalid1 <= gnt1 & bus.req1 & ~bus.we1;
    end
  end

  // NOTE: every output of this block gets a default first; otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    own     = 1'b0;
    own_req = 1'b0;
    oth_req = 1'b0;
    sel     = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        if (bus.req0 || bus.req1) state_n = winner ? ARB_OWN1 : ARB_OWN0;
      end

      ARB_OWN0, ARB_OWN1: begin
        own     = (state == ARB_OWN1);
        own_req = own ? bus.req1 : bus.req0;
        oth_req = own ? bus.req0 : bus.req1;
        sel     = own;
        gnt0    = ~own & bus.req0;
        gnt1    =  own & bus.req1;
        mem_en  = own_req;
        mem_we  = own ? bus.we1 : bus.we0;

        if (own_req) begin
          last_n = own;
          if (oth_req) begin
            // Contended accept: hand over once the burst budget is spent.
            if (cnt == CNT_LAST) begin
              state_n = own ? ARB_OWN0 : ARB_OWN1;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            cnt_n = '0;
          end
        end else if (oth_req) begin
          state_n = own ? ARB_OWN0 : ARB_OWN1;
          cnt_n   = '0;
        end else begin
          state_n = ARB_IDLE;
        end
      end

      default: state_n = ARB_IDLE;
    endcase
  end

  assign addr_mux  = sel ? bus.addr1  : bus.addr0;
  assign wdata_mux = sel ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.rvalid0   = rvalid0;
  assign bus.rvalid1   = rvalid1;
  assign bus.rdata0    = bus.mem_rdata;
  assign bus.rdata1    = bus.mem_rdata;

endmodule
